jesd_tx_framer: RTL and testbench
=================================

# jesd_tx_framer

Transmit-side JESD204B link-layer framer for one lane. It runs the CGS → ILAS → DATA sequence, inserting /K/, /R/, /Q/ and /A/ control characters and applying end-of-frame and end-of-multiframe character replacement. It also emits per-octet frame and multiframe markers aligned with its output. It sits between the TX transport layer (sample-to-octet mapping) and the 8b/10b encoder, and uses the same beat and marker conventions as the receive path. Scrambling is not supported; the data path is unscrambled.

## Interface
- PARALLEL_OCTETS, 4, octets per beat (P). Constraints: F % P == 0 and F*K ≥ 17.
- F, 4, octets per frame.
- K, 8, frames per multiframe.
- ILAS_MULTIFRAMES, 4, number of multiframes in the ILAS.

- clk_i  in  1  clock (single clock domain).
- rst_ni  in  1  reset; synchronous, active-low.
- sync_ni  in  1  SYNC~ from the receiver, already synchronised to clk_i; 0 = resynchronisation request.
- ilas_cfg_i  in  112  ILAS configuration octets 0..13; octet i = [8i+7:8i]. Must be static outside CGS.
- data_i  in  8P  transport octets; octet 0 = [7:0] = earliest.
- data_ready_o  out  1  beat on data_i is consumed this cycle.
- data_o  out  8P  octets to the 8b/10b encoder.
- charisk_o  out  P  per-octet K-character flag.
- sof_o / eof_o / somf_o / eomf_o  out  P each  per-octet start/end of frame/multiframe for the beat on data_o.
- link_up_o  out  1  1 while data_o carries DATA-state beats.

## Operation
- Beat counters run freely from reset and are independent of state:
  - frame counter: 0..F/P-1.
  - multiframe counter (LMFC): 0..F*K/P-1.
- Markers, per beat:
  - sof bit 0 set when frame ctr = 0; eof bit P-1 set when frame ctr = F/P-1.
  - somf bit 0 set when LMFC = 0; eomf bit P-1 set when LMFC = last.
- Octet index within the multiframe: n = LMFC*P + lane.
- CGS:
  - every octet is 0xBC with charisk = 1.
  - Exit to ILAS when sync_ni = 1 on the beat where LMFC = last, so ILAS starts at LMFC = 0.
- ILAS: runs ILAS_MULTIFRAMES multiframes, tracked by an ILAS multiframe counter m. Per octet:
  - n = 0: 0x1C (/R/), K.
  - n = F*K-1: 0x7C (/A/), K.
  - m = 1, n = 1: 0x9C (/Q/), K.
  - m = 1, n = 2..15: ilas_cfg_i octet n-2, data (charisk = 0).
  - otherwise: n[7:0], data.
  - After the last beat of multiframe ILAS_MULTIFRAMES-1, go to DATA.
- DATA:
  - data_ready_o = 1 (combinational from state). data_i is forwarded unchanged except for lane P-1 on beats where frame ctr = F/P-1.
  - In that lane, the original octet d is compared with prev, the original (unreplaced) last octet of the previous frame.
  - If prev is valid and d == prev: emit 0x7C K when LMFC = last, otherwise 0xFC K (/F/).
  - prev is always updated with d, not with the replacement.
  - prev_valid is cleared on DATA entry, so the first DATA frame is never replaced.
- Resynchronisation: sync_ni = 0 sampled in ILAS or DATA moves to CGS on the next beat. data_ready_o drops in the same cycle as the state change, and the ILAS counter and prev_valid are cleared.
- sync_ni = 1 in CGS mid-multiframe: wait for the LMFC boundary. A sync_ni drop before that boundary cancels the exit.
- The counters never reset on state changes; only rst_ni resets them.

## Timing
- Reset values:
  - data_o: all octets 0xBC.
  - charisk_o: all 1.
  - marker outputs, link_up_o, data_ready_o: 0.
  - state: CGS; counters and prev: 0.
- All outputs except data_ready_o are registered.
- Latency: a beat accepted on data_i in cycle t appears on data_o in cycle t+1, with its markers.
- First beat after reset release: outputs show LMFC = 0 (somf_o[0] = 1) one cycle after the first clock with rst_ni = 1.
- link_up_o rises with the first DATA beat on data_o, one cycle after data_ready_o rises.
- ILAS duration is exactly ILAS_MULTIFRAMES*F*K/P beats.
- Reset asserted mid-ILAS or mid-DATA: the next clock restores all reset values.

## Test plan
- Reset, sync_ni = 0 for 20 beats (P=4, F=4, K=8) -> every beat is 0xBCBCBCBC with charisk 0xF; somf_o = 0x1 every 8 beats.
- sync_ni rises at LMFC = 3 -> CGS continues through LMFC = 7. Then 32 ILAS beats:
  - beat 0 octet 0 = 0x1C K; octet 31 of each multiframe = 0x7C K.
  - multiframe 1: octet 1 = 0x9C K, octets 2..15 = ilas_cfg_i.
  - after ILAS, data_ready_o = 1.
- DATA with data_i = 0x44332211 constant -> first frame passes unchanged; later non-end-of-multiframe frames output 0xFC K in lane 3; the end-of-multiframe frame outputs 0x7C K in lane 3.
- DATA with lane-3 sequence 0x55, 0x55, 0x55 -> second and third frames replaced, since comparison uses original octets; 0x55, 0x66 -> no replacement.
- sync_ni pulsed low for 1 cycle in DATA -> 0xBC K output from the next beat; ILAS restarts only at the next LMFC boundary after sync_ni = 1.
- rst_ni low for 1 cycle mid-ILAS -> all reset values next cycle; counters restart from 0.

Source files
------------

// File: rtl/jesd_tx_framer.sv
// JESD204B transmit link-layer framer for one lane: CGS -> ILAS -> DATA sequencing,
// control-character insertion, end-of-frame/multiframe replacement and beat markers.
module jesd_tx_framer #(
  parameter int PARALLEL_OCTETS  = 4,
  parameter int F                = 4,
  parameter int K                = 8,
  parameter int ILAS_MULTIFRAMES = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           sync_ni,
  input  logic [111:0]                   ilas_cfg_i,
  input  logic [8*PARALLEL_OCTETS-1:0]   data_i,
  output logic                           data_ready_o,
  output logic [8*PARALLEL_OCTETS-1:0]   data_o,
  output logic [PARALLEL_OCTETS-1:0]     charisk_o,
  output logic [PARALLEL_OCTETS-1:0]     sof_o,
  output logic [PARALLEL_OCTETS-1:0]     eof_o,
  output logic [PARALLEL_OCTETS-1:0]     somf_o,
  output logic [PARALLEL_OCTETS-1:0]     eomf_o,
  output logic                           link_up_o
);

  localparam int P   = PARALLEL_OCTETS;
  localparam int FPB = F / P;
  localparam int MFB = F * K / P;
  localparam int FW  = (FPB > 1) ? $clog2(FPB) : 1;
  localparam int LW  = (MFB > 1) ? $clog2(MFB) : 1;
  localparam int MW  = (ILAS_MULTIFRAMES > 1) ? $clog2(ILAS_MULTIFRAMES) : 1;

  localparam logic [1:0] ST_CGS  = 2'd0;
  localparam logic [1:0] ST_ILAS = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]      state_reg;
  logic [FW-1:0]   frame_reg;
  logic [LW-1:0]   lmfc_reg;
  logic [MW-1:0]   ilas_mf_reg;
  logic [7:0]      prev_reg;
  logic            prev_valid_reg;

  logic            frame_last;
  logic            lmfc_last;
  logic            ilas_last;
  logic            ilas_m1;
  logic [7:0]      d_last;
  logic [8*P-1:0]  data_next;
  logic [P-1:0]    charisk_next;
  logic [7:0]      cfg_octets [16];

  assign frame_last   = (frame_reg == FW'(FPB - 1));
  assign lmfc_last    = (lmfc_reg == LW'(MFB - 1));
  assign ilas_last    = (ilas_mf_reg == MW'(ILAS_MULTIFRAMES - 1));
  assign ilas_m1      = (ilas_mf_reg == MW'(1));
  assign d_last       = data_i[8*P-1 -: 8];
  assign data_ready_o = (state_reg == ST_DATA);

  // Pad the 14 configuration octets to 16 so the ILAS lookup can use a 4-bit index.
  for (genvar gi = 0; gi < 16; gi++) begin : g_cfg
    if (gi < 14) begin : g_oct
      assign cfg_octets[gi] = ilas_cfg_i[8*gi +: 8];
    end else begin : g_pad
      assign cfg_octets[gi] = 8'h00;
    end
  end

  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    logic [15:0] n;
    logic [7:0]  d;
    logic [7:0]  oct;
    logic        k;

    assign d = data_i[8*gi +: 8];
    assign n = 16'(lmfc_reg) * 16'(P) + 16'(gi);

    always_comb begin
      oct = 8'hBC;
      k   = 1'b1;
      case (state_reg)
        ST_ILAS: begin
          if (n == 16'd0) begin
            oct = 8'h1C;
          end else if (n == 16'(F*K - 1)) begin
            oct = 8'h7C;
          end else if (ilas_m1 && n == 16'd1) begin
            oct = 8'h9C;
          end else if (ilas_m1 && n <= 16'd15) begin
            oct = cfg_octets[4'(n - 16'd2)];
            k   = 1'b0;
          end else begin
            oct = n[7:0];
            k   = 1'b0;
          end
        end
        ST_DATA: begin
          oct = d;
          k   = 1'b0;
          // Only the last octet of a frame is a replacement candidate.
          if (gi == P-1 && frame_last && prev_valid_reg && d == prev_reg) begin
            oct = lmfc_last ? 8'h7C : 8'hFC;
            k   = 1'b1;
          end
        end
        default: ;
      endcase
    end

    assign data_next[8*gi +: 8] = oct;
    assign charisk_next[gi]     = k;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg      <= ST_CGS;
      frame_reg      <= '0;
      lmfc_reg       <= '0;
      ilas_mf_reg    <= '0;
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
      data_o         <= {P{8'hBC}};
      charisk_o      <= '1;
      sof_o          <= '0;
      eof_o          <= '0;
      somf_o         <= '0;
      eomf_o         <= '0;
      link_up_o      <= 1'b0;
    end else begin
      frame_reg <= frame_last ? '0 : frame_reg + 1'b1;
      lmfc_reg  <= lmfc_last ? '0 : lmfc_reg + 1'b1;
      data_o    <= data_next;
      charisk_o <= charisk_next;
      sof_o     <= P'(frame_reg == '0);
      eof_o     <= P'(frame_last) << (P - 1);
      somf_o    <= P'(lmfc_reg == '0);
      eomf_o    <= P'(lmfc_last) << (P - 1);
      link_up_o <= (state_reg == ST_DATA);

      if (state_reg != ST_DATA) prev_valid_reg <= 1'b0;

      case (state_reg)
        ST_CGS: begin
          if (sync_ni && lmfc_last) begin
            state_reg   <= ST_ILAS;
            ilas_mf_reg <= '0;
          end
        end
        ST_ILAS: begin
          if (!sync_ni) begin
            state_reg   <= ST_CGS;
            ilas_mf_reg <= '0;
          end else if (lmfc_last) begin
            if (ilas_last) begin
              state_reg   <= ST_DATA;
              ilas_mf_reg <= '0;
            end else begin
              ilas_mf_reg <= ilas_mf_reg + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (!sync_ni) begin
            state_reg      <= ST_CGS;
            prev_valid_reg <= 1'b0;
          end else if (frame_last) begin
            // Compare against the original octet, never the replacement.
            prev_reg       <= d_last;
            prev_valid_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_CGS;
      endcase
    end
  end

endmodule

// File: tb/tb_jesd_tx_framer.sv
// Directed bench for jesd_tx_framer (P=4, F=4, K=8): CGS, ILAS, DATA replacement,
// resynchronisation and mid-ILAS reset.
module tb_jesd_tx_framer;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          sync_ni;
  logic [111:0]  ilas_cfg_i;
  logic [31:0]   data_i;
  logic          data_ready_o;
  logic [31:0]   data_o;
  logic [3:0]    charisk_o;
  logic [3:0]    sof_o;
  logic [3:0]    eof_o;
  logic [3:0]    somf_o;
  logic [3:0]    eomf_o;
  logic          link_up_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  jesd_tx_framer #(
    .PARALLEL_OCTETS (4),
    .F               (4),
    .K               (8),
    .ILAS_MULTIFRAMES(4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .sync_ni     (sync_ni),
    .ilas_cfg_i  (ilas_cfg_i),
    .data_i      (data_i),
    .data_ready_o(data_ready_o),
    .data_o      (data_o),
    .charisk_o   (charisk_o),
    .sof_o       (sof_o),
    .eof_o       (eof_o),
    .somf_o      (somf_o),
    .eomf_o      (eomf_o),
    .link_up_o   (link_up_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output beat check: F/P = 1, so every beat starts and ends a frame.
  task automatic check_beat(input string tag, input int l, input logic [31:0] ed, input logic [3:0] ek);
    check({tag, "_data"}, 64'(data_o), 64'(ed));
    check({tag, "_charisk"}, 64'(charisk_o), 64'(ek));
    check({tag, "_sof"}, 64'(sof_o), 64'h1);
    check({tag, "_eof"}, 64'(eof_o), 64'h8);
    check({tag, "_somf"}, 64'(somf_o), (l == 0) ? 64'h1 : 64'h0);
    check({tag, "_eomf"}, 64'(eomf_o), (l == 7) ? 64'h8 : 64'h0);
    $display("beat %-10s lmfc=%0d data=%h charisk=%h", tag, l, data_o, charisk_o);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_data"}, 64'(data_o), 64'hBCBCBCBC);
    check({tag, "_charisk"}, 64'(charisk_o), 64'hF);
    check({tag, "_markers"}, 64'({sof_o, eof_o, somf_o, eomf_o}), 64'h0);
    check({tag, "_link_up"}, 64'(link_up_o), 64'h0);
    check({tag, "_ready"}, 64'(data_ready_o), 64'h0);
    $display("reset %-10s data=%h charisk=%h", tag, data_o, charisk_o);
  endtask

  // ILAS octet for multiframe m, multiframe octet n; config octet i is 0xA0+i.
  function automatic logic [8:0] ilas_exp(input int m, input int n);
    if (n == 0)                    return {1'b1, 8'h1C};
    if (n == 31)                   return {1'b1, 8'h7C};
    if (m == 1 && n == 1)          return {1'b1, 8'h9C};
    if (m == 1 && n <= 15)         return {1'b0, 8'(8'hA0 + n - 2)};
    return {1'b0, 8'(n)};
  endfunction

  logic [31:0] din  [13] = '{32'h44332211, 32'h44332211, 32'h44332211, 32'h44332211,
                             32'h44332211, 32'h44332211, 32'h44332211, 32'h44332211,
                             32'h55332211, 32'h55332211, 32'h55332211, 32'h66332211,
                             32'h66332211};
  logic [31:0] dout [13] = '{32'h44332211, 32'hFC332211, 32'hFC332211, 32'hFC332211,
                             32'hFC332211, 32'hFC332211, 32'hFC332211, 32'h7C332211,
                             32'h55332211, 32'hFC332211, 32'hFC332211, 32'h66332211,
                             32'hFC332211};
  logic [3:0]  kout [13] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8,
                             4'h0, 4'h8, 4'h8, 4'h0, 4'h8};

  initial begin
    logic [31:0] ed;
    logic [3:0]  ek;
    logic [8:0]  w;

    rst_ni  = 1'b0;
    sync_ni = 1'b0;
    data_i  = '0;
    for (int i = 0; i < 14; i++) ilas_cfg_i[8*i +: 8] = 8'(8'hA0 + i);
    step();
    step();
    check_reset("rst");

    // CGS: 19 beats with sync_ni low, leaving the LMFC at 3.
    rst_ni = 1'b1;
    for (int j = 0; j < 19; j++) begin
      step();
      check_beat("cgs", j % 8, 32'hBCBCBCBC, 4'hF);
    end

    // sync_ni rises mid-multiframe: CGS holds until the LMFC boundary.
    sync_ni = 1'b1;
    for (int j = 19; j < 24; j++) begin
      step();
      check_beat("cgs_wait", j % 8, 32'hBCBCBCBC, 4'hF);
      check("cgs_wait_ready", 64'(data_ready_o), 64'h0);
    end

    for (int b = 0; b < 32; b++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        w = ilas_exp(b / 8, 4 * (b % 8) + i);
        ed[8*i +: 8] = w[7:0];
        ek[i]        = w[8];
      end
      check_beat("ilas", b % 8, ed, ek);
      check("ilas_ready", 64'(data_ready_o), (b == 31) ? 64'h1 : 64'h0);
      check("ilas_link_up", 64'(link_up_o), 64'h0);
    end

    for (int k = 0; k < 13; k++) begin
      data_i = din[k];
      step();
      check_beat("data", k % 8, dout[k], kout[k]);
      check("data_link_up", 64'(link_up_o), 64'h1);
      check("data_ready", 64'(data_ready_o), 64'h1);
    end

    // One-cycle resync request: the beat consumed that cycle still goes out.
    sync_ni = 1'b0;
    data_i  = 32'h66332211;
    step();
    check_beat("resync", 5, 32'hFC332211, 4'h8);
    check("resync_ready", 64'(data_ready_o), 64'h0);
    sync_ni = 1'b1;
    step();
    check_beat("re_cgs", 6, 32'hBCBCBCBC, 4'hF);
    check("re_cgs_link_up", 64'(link_up_o), 64'h0);
    step();
    check_beat("re_cgs", 7, 32'hBCBCBCBC, 4'hF);
    step();
    check_beat("re_ilas", 0, 32'h0302011C, 4'h1);
    step();
    check_beat("re_ilas", 1, 32'h07060504, 4'h0);

    // Reset mid-ILAS, then counters restart from 0 in CGS.
    rst_ni = 1'b0;
    step();
    check_reset("mid_rst");
    rst_ni = 1'b1;
    step();
    check_beat("post_rst", 0, 32'hBCBCBCBC, 4'hF);
    step();
    check_beat("post_rst", 1, 32'hBCBCBCBC, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
